flit_receiver: RTL and testbench

- Destination-side endpoint of a processor-to-processor burst transfer through the 2x2 router mesh.
- Sits between a router's output_processor port and the local processing unit, and consumes the 9-bit flit stream that the source processing unit injects.
- Decodes the header flit, buffers payload bytes in a FIFO, and delivers them to the local consumer with a valid/ready handshake.
- Pulses transfer_done so the master can release the granted path.

---
 rtl/flit_receiver.sv | 245 ++++++++++++++++++++++++
 tb/tb_flit_receiver.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/flit_receiver.sv
// flit_receiver: destination endpoint for a burst frame arriving over the router mesh.
//   Latency: payload byte readable (rd_valid) one cycle after its flit is sampled;
//            transfer_done / transfer_error assert the cycle after the final flit / timeout.
//   Backpressure: none toward the router; a full FIFO drops the byte and sets sticky overflow.
//
// Ports:
//   clock, reset          - rising-edge clock, asynchronous active-low reset
//   data_from_router      - flit in: [DATA_W] = flit valid, [DATA_W-1:0] = byte
//   rx_busy, rx_len       - frame in progress, length from most recent header
//   transfer_done/_error  - one-cycle completion / abort pulses
//   rd_data/rd_valid/rd_ready - registered FIFO head with valid/ready pop
//   overflow, clear_overflow  - sticky drop flag and its synchronous clear
//
// Build option: define RX_CHECKSUM_EN to expect an XOR trailer flit after the payload
// (also after a zero-length header). Without it the frame ends on its last payload flit.

module flit_receiver #(
  parameter int DATA_W         = 8,
  parameter int FIFO_DEPTH     = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W:0]   data_from_router,
  output logic              rx_busy,
  output logic [7:0]        rx_len,
  output logic              transfer_done,
  output logic              transfer_error,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              overflow,
  input  logic              clear_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  // Sized to hold TIMEOUT_CYCLES itself, so the gap count never wraps before firing.
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] GAP_LAST = TW'(TIMEOUT_CYCLES - 1);

`ifdef RX_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PAYLOAD = 3'd1,
    S_CHECK   = 3'd2,
    S_DONE    = 3'd3,
    S_ERR     = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PAYLOAD = 3'd1,
    S_DONE    = 3'd3,
    S_ERR     = 3'd4
  } state_t;
`endif

  // ---------------------------------------------------------------------------
  // Flit decode
  // ---------------------------------------------------------------------------
  logic              flit_vld;
  logic [DATA_W-1:0] flit_dat;
  logic [7:0]        hdr_len;

  assign flit_vld = data_from_router[DATA_W];
  assign flit_dat = data_from_router[DATA_W-1:0];
  assign hdr_len  = 8'(flit_dat);

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  state_t            state_q;
  logic [7:0]        rx_len_q;
  logic [7:0]        remaining_q;
  logic [TW-1:0]     gap_q;
  logic              done_q;
  logic              err_q;
`ifdef RX_CHECKSUM_EN
  logic [DATA_W-1:0] xor_q;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      rx_len_q    <= '0;
      remaining_q <= '0;
      gap_q       <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef RX_CHECKSUM_EN
      xor_q       <= '0;
`endif
    end else begin
      // Pulses are raised only on the transition edge, so each lasts one cycle.
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (flit_vld) begin
            rx_len_q    <= hdr_len;
            remaining_q <= hdr_len;
            gap_q       <= '0;
`ifdef RX_CHECKSUM_EN
            xor_q       <= '0;
            // Even an empty frame carries a trailer (expected value 0).
            state_q     <= (hdr_len == 8'd0) ? S_CHECK : S_PAYLOAD;
`else
            // Empty frame: report completion without ever leaving IDLE.
            if (hdr_len == 8'd0) begin
              done_q <= 1'b1;
            end else begin
              state_q <= S_PAYLOAD;
            end
`endif
          end
        end

        S_PAYLOAD: begin
          if (flit_vld) begin
            gap_q       <= '0;
            // Dropped bytes still count toward the frame length.
            remaining_q <= remaining_q - 8'd1;
`ifdef RX_CHECKSUM_EN
            xor_q       <= xor_q ^ flit_dat;
            if (remaining_q == 8'd1) begin
              state_q <= S_CHECK;
            end
`else
            if (remaining_q == 8'd1) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
`endif
          end else if (gap_q == GAP_LAST) begin
            state_q <= S_ERR;
            err_q   <= 1'b1;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end

`ifdef RX_CHECKSUM_EN
        S_CHECK: begin
          if (flit_vld) begin
            gap_q <= '0;
            if (flit_dat == xor_q) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_ERR;
              err_q   <= 1'b1;
            end
          end else if (gap_q == GAP_LAST) begin
            state_q <= S_ERR;
            err_q   <= 1'b1;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
`endif

        // A flit arriving in DONE/ERR is not expected by protocol and is ignored.
        S_DONE:  state_q <= S_IDLE;
        S_ERR:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Payload FIFO: extra pointer bit distinguishes full from empty.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              overflow_q, overflow_d;
  logic              fifo_empty, fifo_full;
  logic              push_req, push_ok, pop, drop;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign pop      = !fifo_empty && rd_ready;
  assign push_req = (state_q == S_PAYLOAD) && flit_vld;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push_ok  = push_req && (!fifo_full || pop);
  assign drop     = push_req && fifo_full && !pop;

  always_comb begin
    wr_ptr_d   = wr_ptr_q + (AW+1)'(push_ok);
    rd_ptr_d   = rd_ptr_q + (AW+1)'(pop);
    rd_data_d  = rd_data_q;
    overflow_d = overflow_q;
    // rd_data is a registered copy of the head; refresh it only when a head exists.
    if (wr_ptr_d != rd_ptr_d) begin
      if (rd_ptr_d == wr_ptr_q) begin
        // Queue was (or just became) empty: the new head is the byte written now.
        rd_data_d = flit_dat;
      end else begin
        rd_data_d = mem_q[rd_ptr_d[AW-1:0]];
      end
    end
    // Set wins over clear when both happen in one cycle.
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clear_overflow) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rd_data_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_data_q  <= rd_data_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: entries are only read between the pointers.
  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= flit_dat;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign rx_busy        = (state_q != S_IDLE);
  assign rx_len         = rx_len_q;
  assign transfer_done  = done_q;
  assign transfer_error = err_q;
  assign rd_data        = rd_data_q;
  assign rd_valid       = !fifo_empty;
  assign overflow       = overflow_q;

endmodule

// File: tb/tb_flit_receiver.sv
// Scoreboard bench for flit_receiver: stimulus pushes expected bytes and
// done/error pulses (with their cycle), a negedge monitor pops and compares.
module tb_flit_receiver;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int TO    = 64;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [DW:0]   data_from_router = '0;
  logic          rx_busy;
  logic [7:0]    rx_len;
  logic          transfer_done;
  logic          transfer_error;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic          overflow;
  logic          clear_overflow = 1'b0;

  flit_receiver #(
    .DATA_W(DW), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock), .reset(reset), .data_from_router(data_from_router),
    .rx_busy(rx_busy), .rx_len(rx_len),
    .transfer_done(transfer_done), .transfer_error(transfer_error),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .overflow(overflow), .clear_overflow(clear_overflow)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    bit err;
    int at;
  } ev_t;

  ev_t        exp_ev[$];
  logic [7:0] exp_bytes[$];
  logic [7:0] frame[$];
  int         last_cyc;
  int         errors = 0;
  int         checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor
  ev_t        cur_ev;
  logic [7:0] cur_b;
  always @(negedge clock) begin
    if (rd_valid && rd_ready) begin
      if (exp_bytes.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_extra: got byte %0h, expected no byte (cycle %0d)", rd_data, cyc);
      end else begin
        cur_b = exp_bytes.pop_front();
        check("rd_data", 32'(rd_data), 32'(cur_b));
      end
    end
    if (transfer_done || transfer_error) begin
      if (exp_ev.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pulse_unexpected: got done=%0b err=%0b, expected none (cycle %0d)",
                 transfer_done, transfer_error, cyc);
      end else begin
        cur_ev = exp_ev.pop_front();
        check("pulse_kind", {30'd0, transfer_done, transfer_error},
              cur_ev.err ? 32'd1 : 32'd2);
        check("pulse_cycle", cyc, cur_ev.at);
      end
    end
  end

  // Stimulus helpers: inputs change 1 time unit after the rising edge.
  task automatic flit(input logic [7:0] b);
    @(posedge clock);
    #1;
    data_from_router = {1'b1, b};
    last_cyc = cyc + 1;  // cycle index at which this flit is sampled
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
      data_from_router = {1'b0, 8'($urandom)};  // garbage with valid low
    end
  endtask

  task automatic run_frame(input int gap, input int keep, input bit bad);
    logic [7:0] x;
    x = 8'h00;
    flit(8'(frame.size()));
    foreach (frame[i]) begin
      if (i > 0) idle(gap);
      flit(frame[i]);
      x ^= frame[i];
      if (i < keep) exp_bytes.push_back(frame[i]);
    end
`ifdef RX_CHECKSUM_EN
    flit(x ^ {7'd0, bad});
`endif
    exp_ev.push_back('{bad, last_cyc});
    idle(2);
  endtask

  task automatic drain();
    int n;
    n = 0;
    rd_ready = 1'b1;
    while (exp_bytes.size() != 0 && n < 200) begin
      @(posedge clock);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d bytes left, expected 0", exp_bytes.size());
    end
    @(negedge clock);
    check("drain_rd_valid", 32'(rd_valid), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    check({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
    check({tag, "_rx_busy"},  32'(rx_busy),  32'd0);
    check({tag, "_rx_len"},   32'(rx_len),   32'd0);
    check({tag, "_overflow"}, 32'(overflow), 32'd0);
    check({tag, "_rd_data"},  32'(rd_data),  32'd0);
    check({tag, "_done"},     32'(transfer_done),  32'd0);
    check({tag, "_err"},      32'(transfer_error), 32'd0);
  endtask

  initial begin
    #1 reset = 1'b0;
    idle(2);
    chk_reset_outputs("por");
    @(posedge clock);
    #1 reset = 1'b1;
    idle(2);

    // Reset in the middle of a payload
    rd_ready = 1'b0;
    flit(8'h05);
    flit(8'h01);
    flit(8'h02);
    idle(1);
    check("pre_rst_busy",  32'(rx_busy),  32'd1);
    check("pre_rst_valid", 32'(rd_valid), 32'd1);
    reset = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    @(posedge clock);
    #1 reset = 1'b1;
    idle(2);
    rd_ready = 1'b1;
    frame = '{8'h3C};
    run_frame(0, 1, 1'b0);
    check("after_rst_len", 32'(rx_len), 32'd1);
    drain();

    // Nominal back-to-back frame
    frame = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_frame(0, 4, 1'b0);
    check("nom_len",  32'(rx_len),   32'd4);
    check("nom_ovf",  32'(overflow), 32'd0);
    check("nom_busy", 32'(rx_busy),  32'd0);
    drain();

    // Gaps between flits with consumer backpressure
    rd_ready = 1'b0;
    frame = '{8'h5A, 8'h6B, 8'h7C};
    run_frame(10, 3, 1'b0);
    check("bp_valid", 32'(rd_valid), 32'd1);
    check("bp_head",  32'(rd_data),  32'h5A);
    idle(5);
    check("bp_head_hold", 32'(rd_data), 32'h5A);
    drain();

    // Overflow: 20 bytes into a 16-deep FIFO
    rd_ready = 1'b0;
    frame.delete();
    for (int i = 0; i < 20; i++) frame.push_back(8'(8'h80 + i));
    run_frame(0, DEPTH, 1'b0);
    check("ovf_set",  32'(overflow), 32'd1);
    check("ovf_head", 32'(rd_data),  32'h80);
    check("ovf_len",  32'(rx_len),   32'h14);
    @(posedge clock);
    #1 clear_overflow = 1'b1;
    @(posedge clock);
    #1 clear_overflow = 1'b0;
    check("ovf_clear", 32'(overflow), 32'd0);
    drain();

    // Timeout after 3 of 8 payload bytes
    rd_ready = 1'b0;
    flit(8'h08);
    flit(8'hC1);
    flit(8'hC2);
    flit(8'hC3);
    exp_bytes.push_back(8'hC1);
    exp_bytes.push_back(8'hC2);
    exp_bytes.push_back(8'hC3);
    exp_ev.push_back('{1'b1, last_cyc + TO});
    idle(TO - 4);
    check("to_busy_mid", 32'(rx_busy), 32'd1);
    idle(10);
    check("to_busy_end", 32'(rx_busy),  32'd0);
    check("to_valid",    32'(rd_valid), 32'd1);
    check("to_head",     32'(rd_data),  32'hC1);
    drain();

    // Zero-length frame
    frame.delete();
    run_frame(0, 0, 1'b0);
    check("zero_len", 32'(rx_len), 32'd0);

`ifdef RX_CHECKSUM_EN
    // Trailer matches / mismatches the XOR of the payload
    rd_ready = 1'b0;
    frame = '{8'hA5, 8'h0F};
    run_frame(0, 2, 1'b0);
    drain();
    rd_ready = 1'b0;
    run_frame(0, 2, 1'b1);
    check("ck_bad_valid", 32'(rd_valid), 32'd1);
    check("ck_bad_head",  32'(rd_data),  32'hA5);
    drain();
`endif

    idle(5);
    check("ev_leftover",   exp_ev.size(),    32'd0);
    check("byte_leftover", exp_bytes.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish before 200000");
    $fatal(1);
  end

endmodule
